// File: rtl/cntr_cmd_seq.sv
// Command sequencer for the up/down counter: buffers commands in a small FIFO and expands
// each into registered Enable/Load/UpDown/InData drive. Optional macro CNTR_CMD_HOLD_EN adds a Hold input.
module cntr_cmd_seq #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic [1:0]               CmdOp,
  input  logic [WIDTH-1:0]         CmdData,
  input  logic [LEN_W-1:0]         CmdLen,
  output logic                     Enable,
  output logic                     Load,
  output logic                     UpDown,
  output logic [WIDTH-1:0]         InData,
  output logic                     CmdDone,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   FifoLevel
`ifdef CNTR_CMD_HOLD_EN
  ,
  input  logic                     Hold
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   rem_reg, rem_next;
  logic [1:0]         op_reg, op_next;
  logic               enable_reg, enable_next;
  logic               load_reg, load_next;
  logic               updown_reg, updown_next;
  logic [WIDTH-1:0]   indata_reg, indata_next;
  logic               done_reg, done_next;
  logic               busy_reg, busy_next;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;

  logic [1:0]         op_mem   [DEPTH];
  logic [WIDTH-1:0]   data_mem [DEPTH];
  logic [LEN_W-1:0]   len_mem  [DEPTH];

  logic               hold;
  logic               push, pop, fifo_empty, cmd_open;
  logic               drv_valid;
  logic [1:0]         drv_op;
  logic [1:0]         head_op;
  logic [WIDTH-1:0]   head_data;
  logic [LEN_W-1:0]   head_len;

`ifdef CNTR_CMD_HOLD_EN
  assign hold = Hold;
`else
  assign hold = 1'b0;
`endif

  assign fifo_empty = (level_reg == '0);
  assign CmdReady   = (level_reg != LVL_W'(DEPTH));
  assign push       = CmdValid && CmdReady;
  assign head_op    = op_mem[rd_ptr_reg];
  assign head_data  = data_mem[rd_ptr_reg];
  assign head_len   = len_mem[rd_ptr_reg];

  // rem_reg counts cycles still owed by the current command beyond those already driven,
  // so a held cycle leaves it untouched and the command simply finishes later.
  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    op_next     = op_reg;
    enable_next = 1'b0;
    load_next   = 1'b0;
    done_next   = 1'b0;
    updown_next = updown_reg;
    indata_next = indata_reg;
    pop         = 1'b0;
    drv_valid   = 1'b0;
    drv_op      = op_reg;
    cmd_open    = (state_reg == ST_EXEC) && (rem_reg != '0);

    if (cmd_open) begin
      if (!hold) begin
        rem_next  = rem_reg - LEN_W'(1);
        drv_valid = 1'b1;
        done_next = (rem_reg == LEN_W'(1));
      end
    end else if (!fifo_empty && !hold) begin
      pop        = 1'b1;
      state_next = ST_EXEC;
      op_next    = head_op;
      rem_next   = (head_op == OP_LOAD) ? '0 : head_len;
      drv_valid  = 1'b1;
      drv_op     = head_op;
      done_next  = (head_op == OP_LOAD) || (head_len == '0);
    end else begin
      state_next = ST_IDLE;
    end

    if (drv_valid) begin
      case (drv_op)
        OP_LOAD: begin
          load_next   = 1'b1;
          indata_next = head_data;
        end
        OP_UP: begin
          enable_next = 1'b1;
          updown_next = 1'b1;
        end
        OP_DOWN: begin
          enable_next = 1'b1;
          updown_next = 1'b0;
        end
        default: ;
      endcase
    end

    level_next = level_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    busy_next  = (state_next == ST_EXEC) || (level_next != '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= ST_IDLE;
      rem_reg    <= '0;
      op_reg     <= OP_NOP;
      enable_reg <= 1'b0;
      load_reg   <= 1'b0;
      updown_reg <= 1'b0;
      indata_reg <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      level_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      op_reg     <= op_next;
      enable_reg <= enable_next;
      load_reg   <= load_next;
      updown_reg <= updown_next;
      indata_reg <= indata_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      level_reg  <= level_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      op_mem[wr_ptr_reg]   <= CmdOp;
      data_mem[wr_ptr_reg] <= CmdData;
      len_mem[wr_ptr_reg]  <= CmdLen;
    end
  end

  assign Enable    = enable_reg;
  assign Load      = load_reg;
  assign UpDown    = updown_reg;
  assign InData    = indata_reg;
  assign CmdDone   = done_reg;
  assign Busy      = busy_reg;
  assign FifoLevel = level_reg;

endmodule

// File: tb/tb_cntr_cmd_seq.sv
// Directed testbench for cntr_cmd_seq: hand-computed expectations sampled on the falling edge.
// The Hold scenario is compiled in only when CNTR_CMD_HOLD_EN is defined.
module tb_cntr_cmd_seq;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int DEPTH = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  logic                   Clk;
  logic                   Reset;
  logic                   CmdValid;
  logic                   CmdReady;
  logic [1:0]             CmdOp;
  logic [WIDTH-1:0]       CmdData;
  logic [LEN_W-1:0]       CmdLen;
  logic                   Enable;
  logic                   Load;
  logic                   UpDown;
  logic [WIDTH-1:0]       InData;
  logic                   CmdDone;
  logic                   Busy;
  logic [$clog2(DEPTH):0] FifoLevel;
`ifdef CNTR_CMD_HOLD_EN
  logic                   Hold;
`endif

  int vectors     = 0;
  int miscompares = 0;

  cntr_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .CmdValid  (CmdValid),
    .CmdReady  (CmdReady),
    .CmdOp     (CmdOp),
    .CmdData   (CmdData),
    .CmdLen    (CmdLen),
    .Enable    (Enable),
    .Load      (Load),
    .UpDown    (UpDown),
    .InData    (InData),
    .CmdDone   (CmdDone),
    .Busy      (Busy),
    .FifoLevel (FifoLevel)
`ifdef CNTR_CMD_HOLD_EN
    ,
    .Hold      (Hold)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Present one command for a single rising edge, then withdraw it.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len);
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    CmdLen   = len;
    step(1);
    CmdValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_en;
    logic [7:0] exp_done;
    Reset    = 1'b1;
    CmdValid = 1'b0;
    CmdOp    = OP_NOP;
    CmdData  = '0;
    CmdLen   = '0;
`ifdef CNTR_CMD_HOLD_EN
    Hold     = 1'b0;
`endif
    step(2);
    Reset = 1'b0;

    // Reset state
    check_vec("rst_enable", 32'(Enable), 32'd0);
    check_vec("rst_load", 32'(Load), 32'd0);
    check_vec("rst_indata", 32'(InData), 32'd0);
    check_vec("rst_level", 32'(FifoLevel), 32'd0);
    check_vec("rst_ready", 32'(CmdReady), 32'd1);
    check_vec("rst_busy", 32'(Busy), 32'd0);

    // Reset in the middle of UP len 7 aborts it
    send(OP_UP, 8'h00, 4'd7);
    check_vec("t1_busy_queued", 32'(Busy), 32'd1);
    check_vec("t1_level_queued", 32'(FifoLevel), 32'd1);
    step(1);
    check_vec("t1_enable_first", 32'(Enable), 32'd1);
    step(2);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    check_vec("t1_enable_after_rst", 32'(Enable), 32'd0);
    check_vec("t1_load_after_rst", 32'(Load), 32'd0);
    check_vec("t1_indata_after_rst", 32'(InData), 32'd0);
    check_vec("t1_level_after_rst", 32'(FifoLevel), 32'd0);
    check_vec("t1_ready_after_rst", 32'(CmdReady), 32'd1);
    check_vec("t1_done_after_rst", 32'(CmdDone), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_vec($sformatf("t1_quiet_%0d", i), 32'({Enable, CmdDone, Busy}), 32'd0);
    end

    // LOAD 0x5A followed by UP len 3 with no gap
    send(OP_LOAD, 8'h5A, 4'd0);
    send(OP_UP, 8'h00, 4'd3);
    check_vec("t2_load_strobe", 32'(Load), 32'd1);
    check_vec("t2_load_enable", 32'(Enable), 32'd0);
    check_vec("t2_load_indata", 32'(InData), 32'h5A);
    check_vec("t2_load_done", 32'(CmdDone), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check_vec($sformatf("t2_up%0d_enable", i), 32'(Enable), 32'd1);
      check_vec($sformatf("t2_up%0d_updown", i), 32'(UpDown), 32'd1);
      check_vec($sformatf("t2_up%0d_load", i), 32'(Load), 32'd0);
      check_vec($sformatf("t2_up%0d_done", i), 32'(CmdDone), (i == 3) ? 32'd1 : 32'd0);
    end
    step(1);
    check_vec("t2_idle_enable", 32'(Enable), 32'd0);
    check_vec("t2_idle_updown_held", 32'(UpDown), 32'd1);
    check_vec("t2_idle_indata_held", 32'(InData), 32'h5A);
    check_vec("t2_idle_busy", 32'(Busy), 32'd0);

    // DOWN len 0: one cycle, done in the same cycle
    send(OP_DOWN, 8'h00, 4'd0);
    step(1);
    check_vec("t3_enable", 32'(Enable), 32'd1);
    check_vec("t3_updown", 32'(UpDown), 32'd0);
    check_vec("t3_done", 32'(CmdDone), 32'd1);
    step(1);
    check_vec("t3_after_enable", 32'(Enable), 32'd0);
    check_vec("t3_after_done", 32'(CmdDone), 32'd0);
    check_vec("t3_after_updown_held", 32'(UpDown), 32'd0);

    // FIFO full while UP len 15 executes
    send(OP_UP, 8'h00, 4'd15);
    step(1);
    check_vec("t4_running", 32'(Enable), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check_vec($sformatf("t4_level_before_push%0d", i), 32'(FifoLevel), 32'(i));
      check_vec($sformatf("t4_ready_before_push%0d", i), 32'(CmdReady), (i < 4) ? 32'd1 : 32'd0);
      send(OP_NOP, 8'h00, 4'd0);
    end
    check_vec("t4_level_full", 32'(FifoLevel), 32'd4);
    check_vec("t4_ready_full", 32'(CmdReady), 32'd0);
    step(10);
    check_vec("t4_last_up_enable", 32'(Enable), 32'd1);
    check_vec("t4_last_up_done", 32'(CmdDone), 32'd1);
    check_vec("t4_last_up_ready", 32'(CmdReady), 32'd0);
    step(1);
    check_vec("t4_ready_after_pop", 32'(CmdReady), 32'd1);
    check_vec("t4_level_after_pop", 32'(FifoLevel), 32'd3);
    check_vec("t4_nop_enable", 32'(Enable), 32'd0);
    check_vec("t4_nop_done", 32'(CmdDone), 32'd1);
    step(4);
    check_vec("t4_drained_busy", 32'(Busy), 32'd0);
    check_vec("t4_drained_level", 32'(FifoLevel), 32'd0);

    // UP len 1, NOP len 2, UP len 1 -> Enable 1,1,0,0,0,1,1 then idle
    exp_en   = 8'b0110_0011;
    exp_done = 8'b0101_0010;
    send(OP_UP, 8'h00, 4'd1);
    send(OP_NOP, 8'h00, 4'd2);
    check_vec("t5_en_0", 32'(Enable), 32'(exp_en[0]));
    check_vec("t5_done_0", 32'(CmdDone), 32'(exp_done[0]));
    send(OP_UP, 8'h00, 4'd1);
    check_vec("t5_en_1", 32'(Enable), 32'(exp_en[1]));
    check_vec("t5_done_1", 32'(CmdDone), 32'(exp_done[1]));
    for (int i = 2; i < 8; i++) begin
      step(1);
      check_vec($sformatf("t5_en_%0d", i), 32'(Enable), 32'(exp_en[i]));
      check_vec($sformatf("t5_done_%0d", i), 32'(CmdDone), 32'(exp_done[i]));
    end

`ifdef CNTR_CMD_HOLD_EN
    // Hold for 3 cycles during UP len 5
    begin
      int en_count;
      int done_at;
      en_count = 0;
      done_at  = -1;
      send(OP_UP, 8'h00, 4'd5);
      step(1);
      for (int i = 0; i < 10; i++) begin
        if (Enable) en_count++;
        if (CmdDone) done_at = i;
        if (i >= 1 && i <= 3) check_vec($sformatf("t6_held_%0d", i), 32'({Enable, CmdDone}), 32'd0);
        Hold = (i < 3);
        step(1);
      end
      Hold = 1'b0;
      check_vec("t6_enable_count", 32'(en_count), 32'd6);
      check_vec("t6_done_cycle", 32'(done_at), 32'd8);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
